// File: rtl/ram_responder_if.sv
// Bus between the CPU controller (master) and the RAM responder (slave).
// Strobes are active-low levels sampled on rising CLK; a request is taken only when the slave is idle and armed.
interface ram_responder_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              RAM_RD;
  logic              RAM_WR;
  logic              RAM_MUX;
  logic [ADDR_W-1:0] PC_ADDR;
  logic [ADDR_W-1:0] IR_ADDR;
  logic [DATA_W-1:0] WR_DATA;
  logic [DATA_W-1:0] RD_DATA;
  logic              RD_VALID;
  logic              BUSY;
  logic              ERR;

  // Handshake: master asserts RAM_RD or RAM_WR low; slave raises BUSY the cycle after
  // acceptance, pulses RD_VALID with RD_DATA on read completion, and pulses ERR on an
  // illegal request. A new request needs both strobes sampled high before it is honoured.
  modport master (
    output RAM_RD, RAM_WR, RAM_MUX, PC_ADDR, IR_ADDR, WR_DATA,
    input  RD_DATA, RD_VALID, BUSY, ERR
  );

  modport slave (
    input  RAM_RD, RAM_WR, RAM_MUX, PC_ADDR, IR_ADDR, WR_DATA,
    output RD_DATA, RD_VALID, BUSY, ERR
  );
endinterface

// File: rtl/ram_responder.sv
// Memory-side responder: decodes RAM strobes, runs a wait-stated access on an internal array.
// Optional write protection below PROT_LIMIT is enabled by defining RAM_WP_EN.
module ram_responder #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1,
  parameter int PROT_LIMIT  = 64
) (
  input  logic              CLK,
  input  logic              Reset_n,
  ram_responder_if.slave    bus,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RD_DONE = 3'd3,
    S_WR_DONE = 3'd4
  } state_e;

  localparam bit          HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0]  WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [ADDR_W:0] PROT_LIM = (ADDR_W+1)'(PROT_LIMIT);
`ifdef RAM_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic              armed_q, armed_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q;
  logic              wr_blocked;
  logic              rd_req, wr_req;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign rd_req     = ~bus.RAM_RD;
  assign wr_req     = ~bus.RAM_WR;
  assign wr_blocked = WP_EN && ({1'b0, addr_q} < PROT_LIM);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    armed_d = armed_q;
    err_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    // Re-arming only needs both strobes high; it may happen while an access is running.
    if (bus.RAM_RD && bus.RAM_WR) armed_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (armed_q && (rd_req || wr_req)) begin
          armed_d = 1'b0;
          if (rd_req && wr_req) begin
            err_d = 1'b1;
          end else begin
            addr_d = bus.RAM_MUX ? bus.IR_ADDR : bus.PC_ADDR;
            wait_d = WAIT_LOAD;
            if (wr_req) begin
              wdata_d = bus.WR_DATA;
              state_d = HAS_WAIT ? S_WR_WAIT : S_WR_DONE;
            end else begin
              state_d = HAS_WAIT ? S_RD_WAIT : S_RD_DONE;
            end
          end
        end
      end
      S_RD_WAIT: begin
        if (wait_q == 4'd0) state_d = S_RD_DONE;
        else                wait_d  = wait_q - 4'd1;
      end
      S_WR_WAIT: begin
        if (wait_q == 4'd0) state_d = S_WR_DONE;
        else                wait_d  = wait_q - 4'd1;
      end
      S_RD_DONE: state_d = S_IDLE;
      S_WR_DONE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
      armed_q <= 1'b1;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      armed_q <= armed_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      // Load read data on entry so RD_DATA is already valid during the RD_DONE cycle.
      if (state_d == S_RD_DONE) rdata_q <= mem[addr_d];
    end
  end

  // The array is not reset; an async reset forces IDLE so an in-flight write never commits.
  always_ff @(posedge CLK) begin
    if (state_q == S_WR_DONE && !wr_blocked) mem[addr_q] <= wdata_q;
  end

  assign bus.RD_DATA  = rdata_q;
  assign bus.RD_VALID = (state_q == S_RD_DONE);
  assign bus.BUSY     = (state_q != S_IDLE);
  assign bus.ERR      = err_q | ((state_q == S_WR_DONE) && wr_blocked);
  assign dbg_state_o  = state_q;

endmodule
